// File: rtl/branch_predictor_if.sv
// Bundle between decode/execute and the branch predictor.
//   Decode side:  d_pc, d_isbranch in; d_guess_taken, d_bht_idx out.
//   Execute side: e_valid_br, e_stall, e_flush, e_taken, e_guess_taken, e_bht_idx in;
//                 mispredict out.
//   Statistics:   br_count, miss_count out.
// master: the pipeline side that drives lookups and resolutions.
// slave:  the predictor itself.
interface branch_predictor_if #(
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned CNT_W     = 32
);
  logic [31:0]          d_pc;
  logic                 d_isbranch;
  logic                 d_guess_taken;
  logic [BHT_IDX_W-1:0] d_bht_idx;
  logic                 e_valid_br;
  logic                 e_stall;
  logic                 e_flush;
  logic                 e_taken;
  logic                 e_guess_taken;
  logic [BHT_IDX_W-1:0] e_bht_idx;
  logic                 mispredict;
  logic [CNT_W-1:0]     br_count;
  logic [CNT_W-1:0]     miss_count;

  modport master (
    output d_pc, d_isbranch, e_valid_br, e_stall, e_flush, e_taken, e_guess_taken, e_bht_idx,
    input  d_guess_taken, d_bht_idx, mispredict, br_count, miss_count
  );

  modport slave (
    input  d_pc, d_isbranch, e_valid_br, e_stall, e_flush, e_taken, e_guess_taken, e_bht_idx,
    output d_guess_taken, d_bht_idx, mispredict, br_count, miss_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: table of 2-bit saturating counters indexed by PC,
// with branch/mispredict statistics counters.
// Optional gshare indexing when macro BPU_GSHARE_EN is defined: a non-speculative
// global history register is XORed into the PC index.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   resetn - asynchronous active-low reset
//   bus    - branch_predictor_if.slave (decode lookup, execute resolve, statistics)
module branch_predictor #(
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned CNT_W     = 32
) (
  input  logic               clk,
  input  logic               resetn,
  branch_predictor_if.slave  bus
);

  localparam int unsigned Entries = 1 << BHT_IDX_W;

  logic [1:0]           bht_q [Entries];
  logic [CNT_W-1:0]     br_count_q;
  logic [CNT_W-1:0]     miss_count_q;
  logic [BHT_IDX_W-1:0] pc_idx;
  logic [BHT_IDX_W-1:0] lookup_idx;
  logic [1:0]           cnt_cur;
  logic [1:0]           cnt_nxt;
  logic                 upd;
  logic                 wrong;

  // PC bits outside the index field are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.d_pc[31:BHT_IDX_W+2], bus.d_pc[1:0]};

  assign pc_idx = bus.d_pc[BHT_IDX_W+1:2];

`ifdef BPU_GSHARE_EN
  logic [BHT_IDX_W-1:0] ghr_q;

  assign lookup_idx = pc_idx ^ ghr_q;

  // History only advances on committed (non-stalled, non-flushed) resolutions.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ghr_q <= '0;
    end else if (upd) begin
      ghr_q <= {ghr_q[BHT_IDX_W-2:0], bus.e_taken};
    end
  end
`else
  assign lookup_idx = pc_idx;
`endif

  assign upd   = bus.e_valid_br & ~bus.e_stall & ~bus.e_flush;
  assign wrong = bus.e_taken != bus.e_guess_taken;

  // Lookup reads registered state, so a same-cycle update to the same entry
  // is seen only from the next cycle.
  assign bus.d_bht_idx     = lookup_idx;
  assign bus.d_guess_taken = bus.d_isbranch & bht_q[lookup_idx][1];
  // Not gated by stall: redirect must stay requested while execute is held.
  assign bus.mispredict    = bus.e_valid_br & ~bus.e_flush & wrong;
  assign bus.br_count      = br_count_q;
  assign bus.miss_count    = miss_count_q;

  always_comb begin
    cnt_cur = bht_q[bus.e_bht_idx];
    cnt_nxt = cnt_cur;
    if (bus.e_taken) begin
      if (cnt_cur != 2'd3) cnt_nxt = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != 2'd0) cnt_nxt = cnt_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < Entries; i++) begin
        bht_q[i] <= 2'd1;
      end
    end else if (upd) begin
      bht_q[bus.e_bht_idx] <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else if (upd) begin
      br_count_q <= br_count_q + CNT_W'(1);
      if (wrong) miss_count_q <= miss_count_q + CNT_W'(1);
    end
  end

endmodule
